// File: rtl/qea_engine.sv
// State-vector emulator: fetches 5-word gates from context RAM and applies each 2x2 complex gate in place.
// FETCH 6 cycles/gate, 5 cycles per active pair, 1 per skipped pair; host port is 1-cycle read-first, idle-only.
module qea_engine #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
  parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
  parameter int GATE_ADDR_WIDTH         = 6,
  parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic                                 i_ctx_en,
  input  logic                                 i_ctx_wea,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  input  logic                                 i_state_ena,
  input  logic                                 i_state_wea,
  input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
  output logic                                 o_complete,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dout
);

  localparam int IDXW = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int ROWW = PE_NUM * STATE_DATA_WIDTH;
  localparam int ACCW = 2 * ALU_DATA_WIDTH + 2;

  typedef enum logic [3:0] {IDLE, FETCH, RD_A, RD_B, CALC, WR_A, WR_B, NEXT, DONE} state_t;

  state_t                               st;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   pc;
  logic [GATE_ADDR_WIDTH-1:0]           fc;
  logic                                 last_q, ctrl_q;
  logic [MAX_QBIT_WIDTH-1:0]            t_q, c_q, qn;
  logic [GATE_DATA_WIDTH-1:0]           u_reg [0:3];
  logic [IDXW-1:0]                      p;
  logic [STATE_DATA_WIDTH-1:0]          na0, na1;

  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_mem [0:(1<<GATE_CONTEXT_ADDR_WIDTH)-1];
  logic [ROWW-1:0]                      state_mem [0:(1<<STATE_ADDR_WIDTH)-1];
  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_raddr;
  logic [ROWW-1:0]                      row_a, row_b, wa, wb;

  logic                                 running, skip, last_pair;
  logic [IDXW-1:0]                      one_t, low_mask, i0, i1, pair_max;
  logic [STATE_ADDR_WIDTH-1:0]          row0, row1;
  logic [PE_NUM_WIDTH-1:0]              lane0, lane1;
  logic [STATE_DATA_WIDTH-1:0]          a0, a1;
  logic                                 wr_en;
  logic [STATE_ADDR_WIDTH-1:0]          wr_addr;
  logic [ROWW-1:0]                      wr_data;

  function automatic logic [STATE_DATA_WIDTH-1:0] get_lane(input logic [ROWW-1:0] row,
                                                           input logic [PE_NUM_WIDTH-1:0] lane);
    return row[(PE_NUM-1-int'(lane))*STATE_DATA_WIDTH +: STATE_DATA_WIDTH];
  endfunction

  function automatic logic [ROWW-1:0] put_lane(input logic [ROWW-1:0] row,
                                               input logic [PE_NUM_WIDTH-1:0] lane,
                                               input logic [STATE_DATA_WIDTH-1:0] val);
    logic [ROWW-1:0] r;
    r = row;
    r[(PE_NUM-1-int'(lane))*STATE_DATA_WIDTH +: STATE_DATA_WIDTH] = val;
    return r;
  endfunction

  function automatic logic signed [ACCW-1:0] sx(input logic [ALU_DATA_WIDTH-1:0] v);
    return {{(ACCW-ALU_DATA_WIDTH){v[ALU_DATA_WIDTH-1]}}, v};
  endfunction

  // ua*a + ub*b at full precision, then floor-shifted and wrapped to one {re, im} amplitude
  function automatic logic [STATE_DATA_WIDTH-1:0] mac2(input logic [GATE_DATA_WIDTH-1:0] ua,
                                                       input logic [STATE_DATA_WIDTH-1:0] a,
                                                       input logic [GATE_DATA_WIDTH-1:0] ub,
                                                       input logic [STATE_DATA_WIDTH-1:0] b);
    logic signed [ACCW-1:0] re, im;
    re = sx(ua[2*DATA_WIDTH-1:DATA_WIDTH]) * sx(a[2*DATA_WIDTH-1:DATA_WIDTH])
       - sx(ua[DATA_WIDTH-1:0])            * sx(a[DATA_WIDTH-1:0])
       + sx(ub[2*DATA_WIDTH-1:DATA_WIDTH]) * sx(b[2*DATA_WIDTH-1:DATA_WIDTH])
       - sx(ub[DATA_WIDTH-1:0])            * sx(b[DATA_WIDTH-1:0]);
    im = sx(ua[2*DATA_WIDTH-1:DATA_WIDTH]) * sx(a[DATA_WIDTH-1:0])
       + sx(ua[DATA_WIDTH-1:0])            * sx(a[2*DATA_WIDTH-1:DATA_WIDTH])
       + sx(ub[2*DATA_WIDTH-1:DATA_WIDTH]) * sx(b[DATA_WIDTH-1:0])
       + sx(ub[DATA_WIDTH-1:0])            * sx(b[2*DATA_WIDTH-1:DATA_WIDTH]);
    re = re >>> NUM_FRAC_BIT;
    im = im >>> NUM_FRAC_BIT;
    return {re[DATA_WIDTH-1:0], im[DATA_WIDTH-1:0]};
  endfunction

  assign running   = (st != IDLE) && (st != DONE);
  assign ctx_raddr = pc + GATE_CONTEXT_ADDR_WIDTH'(fc);

  // Pair index: insert a 0 at bit t of p to get i0, i1 is its partner with bit t set
  assign one_t     = IDXW'(1) << t_q;
  assign low_mask  = one_t - IDXW'(1);
  assign i0        = ((p & ~low_mask) << 1) | (p & low_mask);
  assign i1        = i0 | one_t;
  assign row0      = i0[IDXW-1:PE_NUM_WIDTH];
  assign row1      = i1[IDXW-1:PE_NUM_WIDTH];
  assign lane0     = i0[PE_NUM_WIDTH-1:0];
  assign lane1     = i1[PE_NUM_WIDTH-1:0];
  assign pair_max  = (IDXW'(1) << (qn - MAX_QBIT_WIDTH'(1))) - IDXW'(1);
  assign last_pair = (p == pair_max);
  assign skip      = ctrl_q && (((i0 >> c_q) & IDXW'(1)) == '0);

  assign a0 = get_lane(row_a, lane0);
  assign a1 = get_lane(row_b, lane1);
  assign wa = put_lane(row_a, lane0, na0);
  // row_a already carries the WR_A update when both amplitudes share a row
  assign wb = put_lane((row1 == row0) ? row_a : row_b, lane1, na1);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = i_state_addra;
    wr_data = i_state_dina;
    if (st == WR_A) begin
      wr_en   = 1'b1;
      wr_addr = row0;
      wr_data = wa;
    end else if (st == WR_B) begin
      wr_en   = 1'b1;
      wr_addr = row1;
      wr_data = wb;
    end else if (!running && i_state_ena && i_state_wea) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!running && i_ctx_en && i_ctx_wea) ctx_mem[i_ctx_addr] <= i_ctx_data;
    ctx_q <= ctx_mem[ctx_raddr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) state_mem[wr_addr] <= wr_data;
    if (st == RD_A)      row_a <= state_mem[row0];
    else if (st == WR_A) row_a <= wa;
    if (st == RD_B)      row_b <= state_mem[row1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_state_dout <= '0;
    else if (!running && i_state_ena) o_state_dout <= state_mem[i_state_addra];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      pc         <= '0;
      fc         <= '0;
      last_q     <= 1'b0;
      ctrl_q     <= 1'b0;
      t_q        <= '0;
      c_q        <= '0;
      qn         <= '0;
      p          <= '0;
      na0        <= '0;
      na1        <= '0;
      o_complete <= 1'b0;
      for (int k = 0; k < 4; k++) u_reg[k] <= '0;
    end else begin
      case (st)
        IDLE, DONE: begin
          if (i_start) begin
            st         <= FETCH;
            pc         <= '0;
            fc         <= '0;
            qn         <= i_qbit_num;
            o_complete <= 1'b0;
          end
        end
        FETCH: begin
          fc <= fc + GATE_ADDR_WIDTH'(1);
          if (fc == GATE_ADDR_WIDTH'(1)) begin
            last_q <= ctx_q[63];
            ctrl_q <= ctx_q[62];
            t_q    <= ctx_q[55:50];
            c_q    <= ctx_q[49:44];
          end else if (fc >= GATE_ADDR_WIDTH'(2)) begin
            u_reg[2'(fc - GATE_ADDR_WIDTH'(2))] <= ctx_q;
          end
          if (fc == GATE_ADDR_WIDTH'(5)) begin
            st <= RD_A;
            p  <= '0;
          end
        end
        RD_A: begin
          if (!skip)          st <= RD_B;
          else if (last_pair) st <= NEXT;
          else                p  <= p + IDXW'(1);
        end
        RD_B: st <= CALC;
        CALC: begin
          na0 <= mac2(u_reg[0], a0, u_reg[1], a1);
          na1 <= mac2(u_reg[2], a0, u_reg[3], a1);
          st  <= WR_A;
        end
        WR_A: st <= WR_B;
        WR_B: begin
          if (last_pair) st <= NEXT;
          else begin
            p  <= p + IDXW'(1);
            st <= RD_A;
          end
        end
        NEXT: begin
          if (last_q) begin
            st         <= DONE;
            o_complete <= 1'b1;
          end else begin
            pc <= pc + GATE_CONTEXT_ADDR_WIDTH'(5);
            fc <= '0;
            st <= FETCH;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qea_engine.sv
// Directed bench for qea_engine: X, H, CNOT, all-skip control, mid-run reset and host read-first port.
module tb_qea_engine;

  localparam logic [31:0] ONE = 32'h40000000;
  localparam logic [31:0] HP  = 32'h2D413CCD;
  localparam logic [31:0] HN  = 32'hD2BEC333;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [5:0]   i_qbit_num;
  logic         i_ctx_en, i_ctx_wea;
  logic [15:0]  i_ctx_addr;
  logic [63:0]  i_ctx_data;
  logic         i_state_ena, i_state_wea;
  logic [15:0]  i_state_addra;
  logic [255:0] i_state_dina;
  logic         o_complete;
  logic [255:0] o_state_dout;

  int checks = 0;
  int failures = 0;
  int cyc, nz;
  logic [255:0] rd, ket0, pat;

  qea_engine dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_qbit_num(i_qbit_num),
    .i_ctx_en(i_ctx_en), .i_ctx_wea(i_ctx_wea), .i_ctx_addr(i_ctx_addr), .i_ctx_data(i_ctx_data),
    .i_state_ena(i_state_ena), .i_state_wea(i_state_wea), .i_state_addra(i_state_addra),
    .i_state_dina(i_state_dina), .o_complete(o_complete), .o_state_dout(o_state_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] hdr(input bit last, input bit ctrl, input int t, input int c);
    logic [63:0] h;
    h = '0;
    h[63] = last;
    h[62] = ctrl;
    h[55:50] = 6'(t);
    h[49:44] = 6'(c);
    return h;
  endfunction

  function automatic logic [255:0] lanes(input logic [63:0] l0, input logic [63:0] l1,
                                         input logic [63:0] l2, input logic [63:0] l3);
    return {l0, l1, l2, l3};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctx_wr(input int addr, input logic [63:0] data);
    @(negedge clk);
    i_ctx_en = 1'b1; i_ctx_wea = 1'b1; i_ctx_addr = 16'(addr); i_ctx_data = data;
    @(posedge clk); #1;
    i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
  endtask

  task automatic st_rw(input int addr, input bit we, input logic [255:0] din, output logic [255:0] dout);
    @(negedge clk);
    i_state_ena = 1'b1; i_state_wea = we; i_state_addra = 16'(addr); i_state_dina = din;
    @(posedge clk); #1;
    dout = o_state_dout;
    i_state_ena = 1'b0; i_state_wea = 1'b0;
  endtask

  task automatic load_ket0(input int rows);
    logic [255:0] dummy;
    for (int r = 0; r < rows; r++) st_rw(r, 1'b1, (r == 0) ? ket0 : 256'h0, dummy);
  endtask

  task automatic gate_wr(input int base, input logic [63:0] h, input logic [63:0] u00,
                         input logic [63:0] u01, input logic [63:0] u10, input logic [63:0] u11);
    ctx_wr(base, h); ctx_wr(base + 1, u00); ctx_wr(base + 2, u01);
    ctx_wr(base + 3, u10); ctx_wr(base + 4, u11);
  endtask

  // Cycle count = posedges after the start edge until o_complete is seen high
  task automatic run_prog(input string tag, input int poke, output int cyc_o);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check({tag, "_start_clears"}, 256'(o_complete), 256'h0);
    cyc_o = 0;
    while (o_complete !== 1'b1 && cyc_o < 60000) begin
      if (poke > 0 && cyc_o == poke) begin
        @(negedge clk); i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      cyc_o++;
    end
    check({tag, "_complete"}, 256'(o_complete), 256'h1);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_qbit_num = '0;
    i_ctx_en = 1'b0; i_ctx_wea = 1'b0; i_ctx_addr = '0; i_ctx_data = '0;
    i_state_ena = 1'b0; i_state_wea = 1'b0; i_state_addra = '0; i_state_dina = '0;
    ket0 = lanes({ONE, 32'h0}, 64'h0, 64'h0, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_complete", 256'(o_complete), 256'h0);
    check("reset_dout", o_state_dout, 256'h0);
    @(negedge clk); rst_n = 1'b1;

    // n=14, X on qubit 3: amplitude 0 moves to index 8 = row 2 lane 0
    gate_wr(0, hdr(1, 0, 3, 0), 64'h0, {ONE, 32'h0}, {ONE, 32'h0}, 64'h0);
    load_ket0(4096);
    i_qbit_num = 6'd14;
    run_prog("x14", 0, cyc);
    check("x14_cycles", 256'(cyc), 256'd40967);
    st_rw(2, 1'b0, '0, rd);
    check("x14_row2", rd, lanes({ONE, 32'h0}, 64'h0, 64'h0, 64'h0));
    nz = 0;
    for (int r = 0; r < 4096; r++) begin
      if (r != 2) begin
        st_rw(r, 1'b0, '0, rd);
        if (rd !== 256'h0) nz++;
      end
    end
    check("x14_others_zero", 256'(nz), 256'h0);

    // n=2, Hadamard on qubit 0, restarted from DONE
    gate_wr(0, hdr(1, 0, 0, 0), {HP, 32'h0}, {HP, 32'h0}, {HP, 32'h0}, {HN, 32'h0});
    load_ket0(1);
    i_qbit_num = 6'd2;
    run_prog("h2", 0, cyc);
    check("h2_cycles", 256'(cyc), 256'd17);
    st_rw(0, 1'b0, '0, rd);
    check("h2_row0", rd, lanes({HP, 32'h0}, {HP, 32'h0}, 64'h0, 64'h0));

    // n=4, X(t=0) then CNOT(c=0, t=1): |0> -> |1> -> |3>
    gate_wr(0, hdr(0, 0, 0, 0), 64'h0, {ONE, 32'h0}, {ONE, 32'h0}, 64'h0);
    gate_wr(5, hdr(1, 1, 1, 0), 64'h0, {ONE, 32'h0}, {ONE, 32'h0}, 64'h0);
    load_ket0(4);
    i_qbit_num = 6'd4;
    run_prog("cx4", 0, cyc);
    check("cx4_cycles", 256'(cyc), 256'd78);
    st_rw(0, 1'b0, '0, rd);
    check("cx4_row0", rd, lanes(64'h0, 64'h0, 64'h0, {ONE, 32'h0}));
    nz = 0;
    for (int r = 1; r < 4; r++) begin
      st_rw(r, 1'b0, '0, rd);
      if (rd !== 256'h0) nz++;
    end
    check("cx4_others_zero", 256'(nz), 256'h0);

    // n=4, control bit equals target bit: every pair skips, state untouched
    gate_wr(0, hdr(1, 1, 2, 2), 64'h0, {ONE, 32'h0}, {ONE, 32'h0}, 64'h0);
    load_ket0(4);
    run_prog("skip4", 0, cyc);
    check("skip4_cycles", 256'(cyc), 256'd15);
    st_rw(0, 1'b0, '0, rd);
    check("skip4_row0", rd, ket0);
    st_rw(3, 1'b0, '0, rd);
    check("skip4_row3", rd, 256'h0);

    // Reset in the middle of the CNOT program
    gate_wr(0, hdr(0, 0, 0, 0), 64'h0, {ONE, 32'h0}, {ONE, 32'h0}, 64'h0);
    gate_wr(5, hdr(1, 1, 1, 0), 64'h0, {ONE, 32'h0}, {ONE, 32'h0}, 64'h0);
    load_ket0(4);
    @(negedge clk); i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("rst_mid_complete", 256'(o_complete), 256'h0);
    check("rst_mid_idle", 256'(dut.st), 256'h0);
    @(negedge clk); rst_n = 1'b1;
    pat = lanes(64'h1111_2222_3333_4444, 64'h5, 64'h6, 64'h7);
    st_rw(1, 1'b1, pat, rd);
    st_rw(1, 1'b0, '0, rd);
    check("rst_host_port_live", rd, pat);

    // Reload after reset; a start pulse mid-run must be ignored
    gate_wr(0, hdr(0, 0, 0, 0), 64'h0, {ONE, 32'h0}, {ONE, 32'h0}, 64'h0);
    gate_wr(5, hdr(1, 1, 1, 0), 64'h0, {ONE, 32'h0}, {ONE, 32'h0}, 64'h0);
    load_ket0(4);
    i_qbit_num = 6'd4;
    run_prog("rerun", 10, cyc);
    check("rerun_cycles", 256'(cyc), 256'd78);

    // Read-first host port: write zeros, data out is the old row
    st_rw(0, 1'b1, 256'h0, rd);
    check("rdfirst_old", rd, lanes(64'h0, 64'h0, 64'h0, {ONE, 32'h0}));
    st_rw(0, 1'b0, '0, rd);
    check("rdfirst_new", rd, 256'h0);
    st_rw(3, 1'b1, pat, rd);
    st_rw(3, 1'b0, '0, rd);
    check("rd_row3", rd, pat);
    @(negedge clk); i_state_addra = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("dout_hold", o_state_dout, pat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
